alu_exec_ctrl: RTL and testbench
================================

# alu_exec_ctrl

Execute-stage controller directly upstream of the 8-bit `alu`. It accepts 16-bit instructions over a valid/ready handshake and holds a 4×8-bit register file. It drives registered operands and opcode into the combinational ALU, then writes the ALU result back into the destination register and latches the ALU flags into a status register. Load-immediate instructions bypass the ALU.

## Interface
Parameters:
- `NREGS`, 4: register count; fixed at 4, addressed by 2-bit fields.
- `W`, 8: data width; must match the ALU.

Ports (one clock; reset is asynchronous and active-high):
- `CLK` in 1: rising-edge clock.
- `RESET` in 1: asynchronous, active-high reset.
- `INSTR` in 16: instruction word.
  - `[15]` LDI.
  - `[14:12]` OP.
  - `[11:10]` RD.
  - `[9:8]` RA.
  - `[7:6]` RB.
  - `[7:0]` IMM, valid only when LDI=1.
- `INSTR_VALID` in 1: instruction present.
- `INSTR_READY` out 1: controller can accept; equals (state==IDLE).
- `ALU_A` out 8: registered operand A to the ALU.
- `ALU_B` out 8: registered operand B to the ALU.
- `ALU_OP` out 3: registered opcode to the ALU.
- `ALU_Y` in 8: ALU result.
- `ALU_C`, `ALU_N`, `ALU_V`, `ALU_Z` in 1 each: ALU flags.
- `FLAGS` out 4: status register {Z,V,N,C}, i.e. bit 0=C, 1=N, 2=V, 3=Z.
- `DONE` out 1: one-cycle pulse when an instruction retires.
- `DBG_SEL` in 2: register select for debug/display.
- `DBG_DATA` out 8: combinational read of R[DBG_SEL].

## Operation
- States: IDLE, ISSUE, RETIRE.
- **IDLE:** `INSTR_READY`=1. An accept occurs on a rising edge with `INSTR_VALID`=1.
  - LDI=1: R[RD]←IMM at the accept edge; go to RETIRE. `FLAGS` unchanged; `ALU_*` outputs unchanged.
  - LDI=0: `ALU_A`←R[RA], `ALU_B`←R[RB], `ALU_OP`←OP, and RD is latched internally, all at the accept edge; go to ISSUE.
- **ISSUE:** one cycle. `ALU_A`, `ALU_B` and `ALU_OP` are held stable so the ALU settles. At the closing edge, R[RD]←`ALU_Y` and `FLAGS`←{`ALU_Z`,`ALU_V`,`ALU_N`,`ALU_C`}; go to RETIRE.
- **RETIRE:** `DONE`=1 for exactly this cycle; `INSTR_READY`=0; go to IDLE unconditionally.
- Operands are captured at the accept edge. RA==RD or RB==RD therefore reads the old value, and RA==RB is legal.
- `ALU_A`, `ALU_B` and `ALU_OP` hold their last values in IDLE and RETIRE.
- `INSTR` and `INSTR_VALID` are ignored outside IDLE. `INSTR` may change freely after the accept edge.
- `DBG_DATA` reflects a write starting the cycle after the writing edge.
- Register write occurs only at the two edges named above. There is no other write path.

## Timing
- Reset values: R0–R3=0, `ALU_A`=0, `ALU_B`=0, `ALU_OP`=0, `FLAGS`=0, `DONE`=0, state=IDLE, `INSTR_READY`=1.
- `RESET` asserted at any time forces all reset values immediately, regardless of clock. An instruction in ISSUE or RETIRE is abandoned: no write, no `DONE`.
- First accept is possible on the first rising edge after `RESET` deasserts.
- ALU instruction, accept at edge n:
  - operands are visible from edge n;
  - write and flags update at edge n+1;
  - `DONE` is high between edges n+1 and n+2;
  - `INSTR_READY` rises after edge n+2;
  - the next accept is possible at edge n+3.
- LDI instruction, accept at edge n:
  - write at edge n;
  - `DONE` is high between edges n and n+1;
  - the next accept is possible at edge n+2.
- Throughput: one ALU instruction per 3 cycles; one LDI per 2 cycles.
- `INSTR_VALID` held high continuously produces back-to-back accepts at exactly those intervals.

## Test plan
Bench ALU model: OP 3'b000 → Y=A+B (8-bit), with C=carry-out, N=Y[7], Z=(Y==0), V=signed overflow.

1. Reset, then read all `DBG_SEL` values → all reads 0; `FLAGS`=0; `INSTR_READY`=1; `DONE`=0.
2. LDI R1←0x7F, then LDI R2←0x01 → each `DONE` pulse is exactly one cycle; R1=0x7F; R2=0x01; `FLAGS` stays 0.
3. ADD R3=R1+R2 → `ALU_A`=0x7F and `ALU_B`=0x01 on the cycle after accept; R3=0x80; `FLAGS`=4'b0110 (V=1, N=1); `DONE` two edges after accept.
4. LDI R0←0xFF; ADD R0=R0+R2 → R0=0x00; `FLAGS`=4'b1001 (Z=1, C=1). This confirms the old R0 was used as the operand.
5. `INSTR_VALID` held high with three queued instructions → accepts at edges n, n+3, n+6 (ALU instructions); `INSTR` changes while not ready are ignored.
6. Assert `RESET` during ISSUE of ADD R1=R1+R1 with R1=0x10 → R1=0; `DONE` never pulses; state IDLE; `INSTR_READY`=1 immediately.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller for the 8-bit ALU: a 4x8 register file, registered
// operand/opcode drive, write-back of the ALU result and flags, and an LDI bypass.
module alu_exec_ctrl #(
    parameter int NREGS = 4,
    parameter int W     = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [15:0]  INSTR,
    input  logic         INSTR_VALID,
    output logic         INSTR_READY,
    output logic [W-1:0] ALU_A,
    output logic [W-1:0] ALU_B,
    output logic [2:0]   ALU_OP,
    input  logic [W-1:0] ALU_Y,
    input  logic         ALU_C,
    input  logic         ALU_N,
    input  logic         ALU_V,
    input  logic         ALU_Z,
    output logic [3:0]   FLAGS,
    output logic         DONE,
    input  logic [1:0]   DBG_SEL,
    output logic [W-1:0] DBG_DATA
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RETIRE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;

    logic [W-1:0] r_regs [NREGS];
    logic [W-1:0] r_alu_a;
    logic [W-1:0] r_alu_b;
    logic [2:0]   r_alu_op;
    logic [1:0]   r_rd;
    logic [3:0]   r_flags;

    logic         w_ldi;
    logic [2:0]   w_op;
    logic [1:0]   w_rd;
    logic [1:0]   w_ra;
    logic [1:0]   w_rb;
    logic [W-1:0] w_imm;
    logic         w_accept;
    logic         w_wr_en;
    logic [1:0]   w_wr_addr;
    logic [W-1:0] w_wr_data;

    assign w_ldi    = INSTR[15];
    assign w_op     = INSTR[14:12];
    assign w_rd     = INSTR[11:10];
    assign w_ra     = INSTR[9:8];
    assign w_rb     = INSTR[7:6];
    assign w_imm    = INSTR[7:0];
    assign w_accept = (r_state == IDLE) && INSTR_VALID;

    // NOTE: combinational block assigns every output a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (INSTR_VALID) w_state_next = w_ldi ? RETIRE : ISSUE;
            ISSUE:   w_state_next = RETIRE;
            RETIRE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Single register-file write port: LDI at its accept edge, ALU result at the end of ISSUE.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_rd;
        w_wr_data = ALU_Y;
        if (w_accept && w_ldi) begin
            w_wr_en   = 1'b1;
            w_wr_addr = w_rd;
            w_wr_data = w_imm;
        end else if (r_state == ISSUE) begin
            w_wr_en   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the register file is architecturally visible and must read zero after reset, so it is reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[w_wr_addr] <= w_wr_data;
        end
    end

    // Operands are captured at the accept edge, so a destination that aliases a source reads the old value.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_rd     <= '0;
        end else if (w_accept && !w_ldi) begin
            r_alu_a  <= r_regs[w_ra];
            r_alu_b  <= r_regs[w_rb];
            r_alu_op <= w_op;
            r_rd     <= w_rd;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_flags <= '0;
        end else if (r_state == ISSUE) begin
            r_flags <= {ALU_Z, ALU_V, ALU_N, ALU_C};
        end
    end

    assign INSTR_READY = (r_state == IDLE);
    assign DONE        = (r_state == RETIRE);
    assign ALU_A       = r_alu_a;
    assign ALU_B       = r_alu_b;
    assign ALU_OP      = r_alu_op;
    assign FLAGS       = r_flags;
    assign DBG_DATA    = r_regs[DBG_SEL];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: a behavioural ALU drives the DUT, a
// cycle-indexed model predicts every output, and directed vectors pin the model.
module tb_alu_exec_ctrl;

    logic        CLK;
    logic        RESET;
    logic [15:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [2:0]  ALU_OP;
    logic [7:0]  ALU_Y;
    logic        ALU_C;
    logic        ALU_N;
    logic        ALU_V;
    logic        ALU_Z;
    logic [3:0]  FLAGS;
    logic        DONE;
    logic [1:0]  DBG_SEL;
    logic [7:0]  DBG_DATA;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_ctrl dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .ALU_A       (ALU_A),
        .ALU_B       (ALU_B),
        .ALU_OP      (ALU_OP),
        .ALU_Y       (ALU_Y),
        .ALU_C       (ALU_C),
        .ALU_N       (ALU_N),
        .ALU_V       (ALU_V),
        .ALU_Z       (ALU_Z),
        .FLAGS       (FLAGS),
        .DONE        (DONE),
        .DBG_SEL     (DBG_SEL),
        .DBG_DATA    (DBG_DATA)
    );

    // Returns {Z, V, N, C, Y[7:0]}.
    function automatic logic [11:0] alu_eval(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] y;
        logic       c;
        logic       v;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (y[7] != a[7]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 9'd1;
                y = s[7:0];
                c = s[8];
                v = (a[7] != b[7]) && (y[7] != a[7]);
            end
            3'd2:    y = a & b;
            3'd3:    y = a | b;
            3'd4:    y = a ^ b;
            default: y = a;
        endcase
        return {(y == 8'h00), v, y[7], c, y};
    endfunction

    assign {ALU_Z, ALU_V, ALU_N, ALU_C, ALU_Y} = alu_eval(ALU_OP, ALU_A, ALU_B);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model indexed by rising-edge count since reset: each accept schedules its
    // write, its DONE cycle and the earliest edge of the next accept.
    int         m_edge      = 0;
    int         m_next_acc  = 0;
    int         m_done_edge = -1;
    int         m_wr_edge   = -1;
    int         m_acc_edge  = -1;
    logic [7:0] m_regs [4]  = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [3:0] m_flags     = 4'h0;
    logic [7:0] m_a         = 8'h00;
    logic [7:0] m_b         = 8'h00;
    logic [2:0] m_op        = 3'd0;
    logic [1:0] m_pend_rd   = 2'd0;
    logic [7:0] m_pend_y    = 8'h00;
    logic [3:0] m_pend_f    = 4'h0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_edge      <= 0;
            m_next_acc  <= 0;
            m_done_edge <= -1;
            m_wr_edge   <= -1;
            m_acc_edge  <= -1;
            for (int i = 0; i < 4; i++) m_regs[i] <= 8'h00;
            m_flags     <= 4'h0;
            m_a         <= 8'h00;
            m_b         <= 8'h00;
            m_op        <= 3'd0;
        end else begin
            m_edge <= m_edge + 1;
            if (m_wr_edge == m_edge + 1) begin
                m_regs[m_pend_rd] <= m_pend_y;
                m_flags           <= m_pend_f;
            end
            if (INSTR_VALID && (m_edge + 1 >= m_next_acc)) begin
                m_acc_edge <= m_edge + 1;
                if (INSTR[15]) begin
                    m_regs[INSTR[11:10]] <= INSTR[7:0];
                    m_done_edge          <= m_edge + 1;
                    m_next_acc           <= m_edge + 3;
                end else begin
                    m_a                    <= m_regs[INSTR[9:8]];
                    m_b                    <= m_regs[INSTR[7:6]];
                    m_op                   <= INSTR[14:12];
                    {m_pend_f, m_pend_y}   <= alu_eval(INSTR[14:12], m_regs[INSTR[9:8]], m_regs[INSTR[7:6]]);
                    m_pend_rd              <= INSTR[11:10];
                    m_wr_edge              <= m_edge + 2;
                    m_done_edge            <= m_edge + 2;
                    m_next_acc             <= m_edge + 4;
                end
            end
        end
    end

    // Compare process: every falling edge, all outputs plus every register via DBG_SEL.
    initial begin
        DBG_SEL = 2'd0;
        forever begin
            @(negedge CLK);
            check("done",  32'(DONE),        32'(m_done_edge == m_edge));
            check("ready", 32'(INSTR_READY), 32'(m_edge + 1 >= m_next_acc));
            check("flags", 32'(FLAGS),       32'(m_flags));
            check("alu_a", 32'(ALU_A),       32'(m_a));
            check("alu_b", 32'(ALU_B),       32'(m_b));
            check("alu_op",32'(ALU_OP),      32'(m_op));
            for (int s = 0; s < 4; s++) begin
                DBG_SEL = 2'(s);
                #1;
                check($sformatf("dbg_r%0d", s), 32'(DBG_DATA), 32'(m_regs[s]));
            end
        end
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Waits (bounded) for the model to record an accept; returns its edge index or -1.
    task automatic wait_accept(output int acc_edge);
        acc_edge = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (m_acc_edge == m_edge) begin
                acc_edge = m_edge;
                break;
            end
        end
        check("accept_seen", 32'(acc_edge >= 0), 32'd1);
    endtask

    task automatic run_instr(input logic [15:0] ins);
        int ae;
        INSTR       = ins;
        INSTR_VALID = 1'b1;
        wait_accept(ae);
        INSTR_VALID = 1'b0;
    endtask

    initial begin
        int n0, n1, n2;
        INSTR       = 16'h0000;
        INSTR_VALID = 1'b0;
        RESET       = 1'b0;
        #1 RESET    = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RESET    = 1'b0;

        // 1: reset state
        check("rst_ready", 32'(INSTR_READY), 32'd1);
        check("rst_done",  32'(DONE),        32'd0);
        check("rst_flags", 32'(FLAGS),       32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("rst_m_r%0d", i), 32'(m_regs[i]), 32'd0);

        // 2: two LDIs, one-cycle DONE each, FLAGS untouched
        run_instr(16'h847F);
        check("ldi1_done_hi", 32'(DONE), 32'd1);
        step();
        check("ldi1_done_lo", 32'(DONE), 32'd0);
        check("ldi1_ready",   32'(INSTR_READY), 32'd1);
        run_instr(16'h8801);
        check("ldi2_done_hi", 32'(DONE), 32'd1);
        step();
        check("ldi2_done_lo", 32'(DONE), 32'd0);
        check("ldi_flags",    32'(FLAGS), 32'd0);
        check("m_r1_7f",      32'(m_regs[1]), 32'h7F);
        check("m_r2_01",      32'(m_regs[2]), 32'h01);

        // 3: ADD R3 = R1 + R2 -> 0x80, V and N set
        run_instr(16'h0D80);
        check("add_a",     32'(ALU_A),  32'h7F);
        check("add_b",     32'(ALU_B),  32'h01);
        check("add_op",    32'(ALU_OP), 32'd0);
        check("add_ready", 32'(INSTR_READY), 32'd0);
        check("add_done0", 32'(DONE), 32'd0);
        step();
        check("add_done1", 32'(DONE),  32'd1);
        check("add_flags", 32'(FLAGS), 32'b0110);
        step();
        check("add_done2",  32'(DONE), 32'd0);
        check("add_ready2", 32'(INSTR_READY), 32'd1);
        check("m_r3_80",    32'(m_regs[3]), 32'h80);

        // 4: LDI R0 = 0xFF; ADD R0 = R0 + R2 uses the old R0
        run_instr(16'h80FF);
        step();
        run_instr(16'h0080);
        check("wrap_a", 32'(ALU_A), 32'hFF);
        step();
        check("wrap_flags", 32'(FLAGS), 32'b1001);
        step();
        check("m_r0_00", 32'(m_regs[0]), 32'h00);

        // 5: VALID held high, three ALU instructions, junk while busy
        INSTR       = 16'h1F80;
        INSTR_VALID = 1'b1;
        wait_accept(n0);
        check("q0_a",  32'(ALU_A),  32'h80);
        check("q0_op", 32'(ALU_OP), 32'd1);
        INSTR = 16'h85AA;
        step();
        INSTR = 16'h8CFF;
        step();
        INSTR = 16'h21C0;
        wait_accept(n1);
        check("q1_gap", 32'(n1 - n0), 32'd3);
        check("q1_op",  32'(ALU_OP), 32'd2);
        check("q1_a",   32'(ALU_A),  32'h7F);
        check("q1_b",   32'(ALU_B),  32'h7F);
        INSTR = 16'h85AA;
        step();
        INSTR = 16'h8CFF;
        step();
        INSTR = 16'h4A40;
        wait_accept(n2);
        INSTR_VALID = 1'b0;
        INSTR       = 16'h85AA;
        check("q2_gap", 32'(n2 - n1), 32'd3);
        check("q2_op",  32'(ALU_OP), 32'd4);
        check("q2_a",   32'(ALU_A),  32'h01);
        check("q2_b",   32'(ALU_B),  32'h7F);
        step();
        step();
        check("q_flags", 32'(FLAGS), 32'd0);
        step();
        check("m_q_r0", 32'(m_regs[0]), 32'h7F);
        check("m_q_r1", 32'(m_regs[1]), 32'h7F);
        check("m_q_r2", 32'(m_regs[2]), 32'h7E);
        check("m_q_r3", 32'(m_regs[3]), 32'h7F);

        // 6: reset during ISSUE abandons the instruction
        run_instr(16'h8410);
        step();
        run_instr(16'h0540);
        #1 RESET = 1'b1;
        #1;
        check("ar_ready", 32'(INSTR_READY), 32'd1);
        check("ar_done",  32'(DONE),  32'd0);
        check("ar_flags", 32'(FLAGS), 32'd0);
        check("ar_alu_a", 32'(ALU_A), 32'd0);
        step();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ar_no_done", 32'(DONE), 32'd0);
        end
        check("m_ar_r1", 32'(m_regs[1]), 32'h00);
        run_instr(16'h8433);
        step();
        check("m_post_r1", 32'(m_regs[1]), 32'h33);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
